fetch_ctl: RTL

FETCH_CTL -- requirements
Module: fetch_ctl

---
 rtl/fetch_ctl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctl.sv
// fetch_ctl: single-outstanding instruction fetch controller.
// Issues one memory request at a time, forwards each response to decode,
// parks a response in a one-entry hold buffer while decode is stalled, and
// restarts at a new target on redirect (discarding any in-flight response).
module fetch_ctl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] pc_if,
   output logic [31:0] instr_if,
   output logic        valid_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        drop_q, drop_d;
   logic [31:0] hold_q, hold_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic [31:0] pc_if_q, pc_if_d;
   logic [31:0] instr_if_q, instr_if_d;
   logic        valid_if_q, valid_if_d;

   // Word-aligned redirect target.
   logic [31:0] redir_pc;
   assign redir_pc = {redirect_pc[31:2], 2'b00};

   // Next-state, datapath and registered-output decisions.
   always_comb begin
      logic        load;
      logic [31:0] load_instr;

      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_d      = drop_q;
      hold_d      = hold_q;
      pc_if_d     = pc_if_q;
      instr_if_d  = instr_if_q;
      valid_if_d  = valid_if_q;
      load        = 1'b0;
      load_instr  = imem_rsp_data;

      if (redirect_valid) begin
         // Redirect wins over everything, stalled or not.
         fetch_pc_d = redir_pc;
         valid_if_d = 1'b0;
         instr_if_d = NOP_INSTR;
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (imem_ready) begin
                  // The old address was just accepted: its response must be thrown away.
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  state_d = S_REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end
            end
            default: state_d = S_REQ;   // HOLD: held word is stale
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (imem_ready) begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (!stall) begin
                     load       = 1'b1;
                     load_instr = imem_rsp_data;
                     fetch_pc_d = fetch_pc_q + 32'd4;
                     state_d    = S_REQ;
                  end else begin
                     hold_d  = imem_rsp_data;
                     state_d = S_HOLD;
                  end
               end
            end
            default: begin
               if (!stall) begin
                  load       = 1'b1;
                  load_instr = hold_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = S_REQ;
               end
            end
         endcase

         if (load) begin
            pc_if_d    = fetch_pc_q;
            instr_if_d = load_instr;
            valid_if_d = 1'b1;
         end else if (!stall) begin
            // Decode consumed whatever was there; present a bubble.
            valid_if_d = 1'b0;
            instr_if_d = NOP_INSTR;
         end
      end

      // Request outputs track the state being entered so they are registered
      // yet line up with the REQ state.
      imem_req_d  = (state_d == S_REQ);
      imem_addr_d = (state_d == S_REQ) ? fetch_pc_d : imem_addr_q;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_q      <= 1'b0;
         hold_q      <= 32'h0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= 32'h0;
         pc_if_q     <= 32'h0;
         instr_if_q  <= NOP_INSTR;
         valid_if_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_q      <= drop_d;
         hold_q      <= hold_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         pc_if_q     <= pc_if_d;
         instr_if_q  <= instr_if_d;
         valid_if_q  <= valid_if_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign pc_if     = pc_if_q;
   assign instr_if  = instr_if_q;
   assign valid_if  = valid_if_q;

endmodule
